line_dbuf: RTL and testbench

LINE_DBUF -- requirements
Module: line_dbuf

---
 rtl/line_dbuf_pkg.sv | 12 +
 rtl/line_dbuf_if.sv | 31 +++
 rtl/line_dbuf_ram.sv | 25 ++
 rtl/line_dbuf.sv | 145 ++++++++++++++
 tb/tb_line_dbuf.sv | 177 +++++++++++++++++
 5 files changed

// File: rtl/line_dbuf_pkg.sv
// Shared constants for the line double buffer: default geometry and the
// priority encodings used to pick which opaque sprite pixel survives.
package line_dbuf_pkg;

  localparam int DW_DEF = 11;
  localparam int AW_DEF = 9;
  localparam int TW_DEF = 4;

  localparam int PRIO_FIRST = 0;
  localparam int PRIO_LAST  = 1;

endpackage

// File: rtl/line_dbuf_if.sv
// Sprite-engine / video-output port bundle of the line double buffer.
// The master side drives requests; the buffer itself is the slave.
interface line_dbuf_if
  import line_dbuf_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int AW = AW_DEF
) ();

  logic          swap;
  logic          wr_en;
  logic [AW-1:0] wr_adr;
  logic [DW-1:0] wr_dat;
  logic          rd_en;
  logic [AW-1:0] rd_adr;
  logic [DW-1:0] rd_dat;
  logic          rd_vld;
  logic          wbank;
  logic          init_done;

  modport master (
    output swap, wr_en, wr_adr, wr_dat, rd_en, rd_adr,
    input  rd_dat, rd_vld, wbank, init_done
  );

  modport slave (
    input  swap, wr_en, wr_adr, wr_dat, rd_en, rd_adr,
    output rd_dat, rd_vld, wbank, init_done
  );

endinterface

// File: rtl/line_dbuf_ram.sv
// One line bank: simple dual-port RAM, one write and one registered read
// port; a read of the address being written returns the old word.
module line_dbuf_ram
  import line_dbuf_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int AW = AW_DEF
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] wadr_i,
  input  logic [DW-1:0] wdat_i,
  input  logic          re_i,
  input  logic [AW-1:0] radr_i,
  output logic [DW-1:0] rdat_o
);

  logic [DW-1:0] mem [2**AW];

  always_ff @(posedge clk) begin
    if (we_i) mem[wadr_i] <= wdat_i;
    if (re_i) rdat_o <= mem[radr_i];
  end

endmodule

// File: rtl/line_dbuf.sv
// Sprite line double buffer: the sprite engine composites into one bank
// while video scans out (and optionally clears) the other; swap flips roles.
module line_dbuf
  import line_dbuf_pkg::*;
#(
  parameter int DW   = DW_DEF,
  parameter int AW   = AW_DEF,
  parameter int TW   = TW_DEF,
  parameter int PRIO = PRIO_FIRST,
  parameter int RCLR = 1
) (
  input logic       clk,
  input logic       rst_n,
  line_dbuf_if.slave bus
);

  localparam logic [AW-1:0] ADR_LAST = '1;

  logic          wbank_q, wbank_d;
  logic          initDone_q, initDone_d;
  logic [AW-1:0] clrCnt_q, clrCnt_d;

  logic          s1Vld_q, s1Bank_q;
  logic [AW-1:0] s1Adr_q;
  logic [DW-1:0] s1Dat_q;
  logic          s2Vld_q, s2Bank_q;
  logic [AW-1:0] s2Adr_q;
  logic [DW-1:0] s2Word_q;

  logic          rdVld_q, rdBank_q;
  logic [DW-1:0] rdHold_q, rdDat;

  logic          rbank, wrAcc, rdAcc, pipeWe;
  logic [DW-1:0] existing;

  logic          ramWe   [2];
  logic [AW-1:0] ramWadr [2];
  logic [DW-1:0] ramWdat [2];
  logic          ramRe   [2];
  logic [AW-1:0] ramRadr [2];
  logic [DW-1:0] ramRdat [2];

  assign rbank = ~wbank_q;
  assign wrAcc = bus.wr_en & initDone_q;
  assign rdAcc = bus.rd_en & initDone_q;

  always_comb begin
    wbank_d    = wbank_q ^ bus.swap;
    clrCnt_d   = clrCnt_q;
    initDone_d = initDone_q;
    if (!initDone_q) begin
      if (clrCnt_q == ADR_LAST) initDone_d = 1'b1;
      else                      clrCnt_d   = clrCnt_q + AW'(1);
    end
  end

  // The word written last cycle is not yet visible through the RAM read port.
  always_comb begin
    existing = ramRdat[s1Bank_q];
    if (s2Vld_q && (s2Bank_q == s1Bank_q) && (s2Adr_q == s1Adr_q))
      existing = s2Word_q;
    pipeWe = 1'b0;
    if (s1Vld_q && (s1Dat_q[TW-1:0] != '0))
      pipeWe = (PRIO == PRIO_LAST) || (existing[TW-1:0] == '0);
  end

  // Should a write land in the new read bank right after a swap, it wins over
  // that cycle's read-clear: losing sprite data is worse than a stale pixel.
  always_comb begin
    for (int b = 0; b < 2; b++) begin
      ramWe[b]   = 1'b0;
      ramWadr[b] = '0;
      ramWdat[b] = '0;
      ramRe[b]   = 1'b0;
      ramRadr[b] = '0;
      if (!initDone_q) begin
        ramWe[b]   = 1'b1;
        ramWadr[b] = clrCnt_q;
      end else if (pipeWe && (s1Bank_q == b[0])) begin
        ramWe[b]   = 1'b1;
        ramWadr[b] = s1Adr_q;
        ramWdat[b] = s1Dat_q;
      end else if ((RCLR != 0) && rdAcc && (rbank == b[0])) begin
        ramWe[b]   = 1'b1;
        ramWadr[b] = bus.rd_adr;
      end
      if (wrAcc && (wbank_q == b[0])) begin
        ramRe[b]   = 1'b1;
        ramRadr[b] = bus.wr_adr;
      end else if (rdAcc && (rbank == b[0])) begin
        ramRe[b]   = 1'b1;
        ramRadr[b] = bus.rd_adr;
      end
    end
  end

  for (genvar g = 0; g < 2; g++) begin : gBank
    line_dbuf_ram #(.DW(DW), .AW(AW)) uRam (
      .clk    (clk),
      .we_i   (ramWe[g]),
      .wadr_i (ramWadr[g]),
      .wdat_i (ramWdat[g]),
      .re_i   (ramRe[g]),
      .radr_i (ramRadr[g]),
      .rdat_o (ramRdat[g])
    );
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wbank_q    <= 1'b0;
      initDone_q <= 1'b0;
      clrCnt_q   <= '0;
      s1Vld_q    <= 1'b0;
      s2Vld_q    <= 1'b0;
      rdVld_q    <= 1'b0;
      rdHold_q   <= '0;
    end else begin
      wbank_q    <= wbank_d;
      initDone_q <= initDone_d;
      clrCnt_q   <= clrCnt_d;
      s1Vld_q    <= wrAcc;
      s2Vld_q    <= pipeWe;
      rdVld_q    <= rdAcc;
      rdHold_q   <= rdDat;
    end
  end

  always_ff @(posedge clk) begin
    s1Adr_q  <= bus.wr_adr;
    s1Dat_q  <= bus.wr_dat;
    s1Bank_q <= wbank_q;
    s2Adr_q  <= s1Adr_q;
    s2Bank_q <= s1Bank_q;
    s2Word_q <= s1Dat_q;
    rdBank_q <= rbank;
  end

  assign rdDat         = rdVld_q ? ramRdat[rdBank_q] : rdHold_q;
  assign bus.rd_dat    = rdDat;
  assign bus.rd_vld    = rdVld_q;
  assign bus.wbank     = wbank_q;
  assign bus.init_done = initDone_q;

endmodule

// File: tb/tb_line_dbuf.sv
// Directed bench for line_dbuf: A is first-wins with read-clear, B is
// last-wins without read-clear; both see identical stimulus.
module tb_line_dbuf;
  import line_dbuf_pkg::*;

  localparam int DW = DW_DEF;
  localparam int AW = AW_DEF;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  line_dbuf_if #(.DW(DW), .AW(AW)) busA ();
  line_dbuf_if #(.DW(DW), .AW(AW)) busB ();

  assign busB.swap   = busA.swap;
  assign busB.wr_en  = busA.wr_en;
  assign busB.wr_adr = busA.wr_adr;
  assign busB.wr_dat = busA.wr_dat;
  assign busB.rd_en  = busA.rd_en;
  assign busB.rd_adr = busA.rd_adr;

  line_dbuf #(.DW(DW), .AW(AW), .TW(TW_DEF), .PRIO(PRIO_FIRST), .RCLR(1)) dutA (
    .clk(clk), .rst_n(rst_n), .bus(busA)
  );
  line_dbuf #(.DW(DW), .AW(AW), .TW(TW_DEF), .PRIO(PRIO_LAST), .RCLR(0)) dutB (
    .clk(clk), .rst_n(rst_n), .bus(busB)
  );

  task automatic applyStimulus(input logic sw, input logic we, input logic [AW-1:0] wa,
                               input logic [DW-1:0] wd, input logic re, input logic [AW-1:0] ra);
    busA.swap   = sw;
    busA.wr_en  = we;
    busA.wr_adr = wa;
    busA.wr_dat = wd;
    busA.rd_en  = re;
    busA.rd_adr = ra;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, '0, '0, 1'b0, '0);
  endtask

  task automatic test_reset();
    int n = 0;
    int vldBad = 0;
    logic [1:0] wbMid = 2'b00;
    rst_n = 1'b0;
    idle(2);
    checks++; if ({busA.wbank, busB.wbank} !== 2'b00) begin errors++; $display("[TB] FAIL reset_wbank: got %b expected 00", {busA.wbank, busB.wbank}); end
    checks++; if ({busA.rd_vld, busB.rd_vld} !== 2'b00) begin errors++; $display("[TB] FAIL reset_rd_vld: got %b expected 00", {busA.rd_vld, busB.rd_vld}); end
    checks++; if ({busA.init_done, busB.init_done} !== 2'b00) begin errors++; $display("[TB] FAIL reset_init_done: got %b expected 00", {busA.init_done, busB.init_done}); end
    checks++; if (busA.rd_dat !== '0 || busB.rd_dat !== '0) begin errors++; $display("[TB] FAIL reset_rd_dat: got %h/%h expected 000/000", busA.rd_dat, busB.rd_dat); end
    rst_n = 1'b1;
    while (busA.init_done !== 1'b1 && n < 600) begin
      applyStimulus(n == 10 || n == 20, 1'b1, AW'(5), DW'('h0FF), 1'b1, AW'(5));
      n++;
      if (busA.rd_vld !== 1'b0 || busB.rd_vld !== 1'b0) vldBad++;
      if (n == 15) wbMid = {busA.wbank, busB.wbank};
    end
    idle(1);
    checks++; if (n !== 512) begin errors++; $display("[TB] FAIL init_cycles: got %0d expected 512", n); end
    checks++; if (busB.init_done !== 1'b1) begin errors++; $display("[TB] FAIL init_done_B: got %b expected 1", busB.init_done); end
    checks++; if (vldBad !== 0) begin errors++; $display("[TB] FAIL rd_vld_during_init: got %0d cycles expected 0", vldBad); end
    checks++; if (wbMid !== 2'b11) begin errors++; $display("[TB] FAIL swap_during_init: got %b expected 11", wbMid); end
  endtask

  task automatic test_all_zero();
    for (int pass = 0; pass < 2; pass++) begin
      int bad = 0;
      for (int a = 0; a < 2**AW; a++) begin
        applyStimulus(1'b0, 1'b0, '0, '0, 1'b1, AW'(a));
        if (busA.rd_vld !== 1'b1 || busB.rd_vld !== 1'b1 || busA.rd_dat !== '0 || busB.rd_dat !== '0) bad++;
      end
      checks++; if (bad !== 0) begin errors++; $display("[TB] FAIL zero_after_init_pass%0d: got %0d bad reads expected 0", pass, bad); end
      applyStimulus(1'b1, 1'b0, '0, '0, 1'b0, '0);
    end
    idle(1);
  endtask

  task automatic test_prio();
    applyStimulus(1'b0, 1'b1, AW'(5), DW'('h123), 1'b0, '0);
    idle(1);
    applyStimulus(1'b0, 1'b1, AW'(5), DW'('h456), 1'b0, '0);
    idle(1);
    applyStimulus(1'b0, 1'b1, AW'(5), DW'('h450), 1'b0, '0);
    idle(2);
    applyStimulus(1'b1, 1'b0, '0, '0, 1'b0, '0);
    applyStimulus(1'b0, 1'b0, '0, '0, 1'b1, AW'(5));
    checks++; if (busA.rd_dat !== DW'('h123)) begin errors++; $display("[TB] FAIL prio_first: got %h expected 123", busA.rd_dat); end
    checks++; if (busB.rd_dat !== DW'('h456)) begin errors++; $display("[TB] FAIL prio_last: got %h expected 456", busB.rd_dat); end
    checks++; if ({busA.rd_vld, busB.rd_vld} !== 2'b11) begin errors++; $display("[TB] FAIL prio_rd_vld: got %b expected 11", {busA.rd_vld, busB.rd_vld}); end
    idle(1);
    checks++; if ({busA.rd_vld, busB.rd_vld} !== 2'b00) begin errors++; $display("[TB] FAIL idle_rd_vld: got %b expected 00", {busA.rd_vld, busB.rd_vld}); end
    checks++; if (busA.rd_dat !== DW'('h123) || busB.rd_dat !== DW'('h456)) begin errors++; $display("[TB] FAIL rd_dat_hold: got %h/%h expected 123/456", busA.rd_dat, busB.rd_dat); end
  endtask

  task automatic test_transparent();
    applyStimulus(1'b0, 1'b1, AW'(7), DW'('h120), 1'b0, '0);
    idle(2);
    applyStimulus(1'b1, 1'b0, '0, '0, 1'b0, '0);
    checks++; if ({busA.rd_vld, busB.rd_vld} !== 2'b00) begin errors++; $display("[TB] FAIL transp_pre_vld: got %b expected 00", {busA.rd_vld, busB.rd_vld}); end
    applyStimulus(1'b0, 1'b0, '0, '0, 1'b1, AW'(7));
    checks++; if ({busA.rd_vld, busB.rd_vld} !== 2'b11) begin errors++; $display("[TB] FAIL transp_rd_vld: got %b expected 11", {busA.rd_vld, busB.rd_vld}); end
    checks++; if (busA.rd_dat !== '0 || busB.rd_dat !== '0) begin errors++; $display("[TB] FAIL transp_data: got %h/%h expected 000/000", busA.rd_dat, busB.rd_dat); end
    idle(1);
  endtask

  task automatic test_back_to_back();
    applyStimulus(1'b0, 1'b1, AW'(9), DW'('h001), 1'b0, '0);
    applyStimulus(1'b0, 1'b1, AW'(9), DW'('h002), 1'b0, '0);
    idle(2);
    applyStimulus(1'b1, 1'b0, '0, '0, 1'b0, '0);
    applyStimulus(1'b0, 1'b0, '0, '0, 1'b1, AW'(9));
    checks++; if (busA.rd_dat !== DW'('h001) || busB.rd_dat !== DW'('h002)) begin errors++; $display("[TB] FAIL b2b_first_read: got %h/%h expected 001/002", busA.rd_dat, busB.rd_dat); end
    applyStimulus(1'b0, 1'b0, '0, '0, 1'b1, AW'(9));
    checks++; if (busA.rd_dat !== DW'('h000) || busB.rd_dat !== DW'('h002)) begin errors++; $display("[TB] FAIL b2b_second_read: got %h/%h expected 000/002", busA.rd_dat, busB.rd_dat); end
    idle(1);
  endtask

  task automatic test_swap_write();
    applyStimulus(1'b1, 1'b1, AW'(3), DW'('h0AF), 1'b0, '0);
    idle(2);
    applyStimulus(1'b0, 1'b0, '0, '0, 1'b1, AW'(3));
    checks++; if (busA.rd_dat !== DW'('h0AF) || busB.rd_dat !== DW'('h0AF)) begin errors++; $display("[TB] FAIL swap_write_old_bank: got %h/%h expected 0af/0af", busA.rd_dat, busB.rd_dat); end
    applyStimulus(1'b1, 1'b0, '0, '0, 1'b0, '0);
    applyStimulus(1'b0, 1'b0, '0, '0, 1'b1, AW'(3));
    checks++; if (busA.rd_dat !== '0 || busB.rd_dat !== '0) begin errors++; $display("[TB] FAIL swap_write_new_bank: got %h/%h expected 000/000", busA.rd_dat, busB.rd_dat); end
    idle(1);
  endtask

  task automatic test_mid_reset();
    int n = 0;
    rst_n = 1'b0;
    idle(1);
    rst_n = 1'b1;
    idle(100);
    checks++; if ({busA.init_done, busB.init_done} !== 2'b00) begin errors++; $display("[TB] FAIL mid_clear_init_done: got %b expected 00", {busA.init_done, busB.init_done}); end
    applyStimulus(1'b1, 1'b0, '0, '0, 1'b0, '0);
    rst_n = 1'b0;
    idle(1);
    checks++; if ({busA.wbank, busB.wbank} !== 2'b00) begin errors++; $display("[TB] FAIL mid_reset_wbank: got %b expected 00", {busA.wbank, busB.wbank}); end
    rst_n = 1'b1;
    while (busA.init_done !== 1'b1 && n < 600) begin
      idle(1);
      n++;
    end
    checks++; if (n !== 512) begin errors++; $display("[TB] FAIL restart_init_cycles: got %0d expected 512", n); end
    checks++; if ({busA.wbank, busB.init_done} !== 2'b01) begin errors++; $display("[TB] FAIL restart_final: got %b expected 01", {busA.wbank, busB.init_done}); end
  endtask

  initial begin
    rst_n       = 1'b0;
    busA.swap   = 1'b0;
    busA.wr_en  = 1'b0;
    busA.wr_adr = '0;
    busA.wr_dat = '0;
    busA.rd_en  = 1'b0;
    busA.rd_adr = '0;
    $display("[TB] starting line_dbuf bench");
    test_reset();
    test_all_zero();
    test_prio();
    test_transparent();
    test_back_to_back();
    test_swap_write();
    test_mid_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
